// File: rtl/xgmii_pkg.sv
// Shared definitions for the XGMII transmit encoder.
// Holds the XGMII control characters, the fixed preamble/SFD word, the
// encoder state type, and the helper that sizes the inter-packet gap.
package xgmii_pkg;

  localparam logic [7:0]  XGMII_IDLE   = 8'h07;
  localparam logic [7:0]  XGMII_START  = 8'hFB;
  localparam logic [7:0]  XGMII_TERM   = 8'hFD;
  localparam logic [7:0]  XGMII_ERROR  = 8'hFE;
  localparam logic [63:0] PREAMBLE_SFD = 64'hD555555555555555;

  localparam logic [63:0] IDLE_WORD  = {8{XGMII_IDLE}};
  localparam logic [63:0] ERROR_WORD = {8{XGMII_ERROR}};

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TERM,
    IPG
  } state_t;

  // Whole idle words still owed after the terminate word has already
  // supplied 'idles' idle characters. Saturates at zero in 8-bit math.
  function automatic logic [7:0] ipg_word_count(input logic [7:0] min_ipg,
                                                input logic [7:0] idles);
    logic [7:0] deficit;
    deficit = (min_ipg > idles) ? (min_ipg - idles) : 8'd0;
    return (deficit + 8'd7) >> 3;
  endfunction

endpackage

// File: rtl/xgmii_tx_encoder_if.sv
// Frame-word stream from the MAC frame generator into the XGMII encoder.
//   i_data       : 64-bit frame word, byte 0 in [7:0]
//   i_valid      : i_data is valid
//   i_last       : word carries the final frame byte
//   i_last_bytes : valid bytes in the last word (0 means 8)
//   o_ready      : encoder accepts a word this cycle
interface xgmii_tx_encoder_if;

  logic [63:0] i_data;
  logic        i_valid;
  logic        i_last;
  logic [2:0]  i_last_bytes;
  logic        o_ready;

  modport master (
    output i_data,
    output i_valid,
    output i_last,
    output i_last_bytes,
    input  o_ready
  );

  modport slave (
    input  i_data,
    input  i_valid,
    input  i_last,
    input  i_last_bytes,
    output o_ready
  );

endinterface

// File: rtl/xgmii_term_word.sv
// Builds the XGMII word that closes a frame.
//   data : last frame word, byte 0 in [7:0]
//   n    : number of data bytes in the word (0..8)
//   txd  : lanes 0..n-1 data, lane n /T/, lanes above /I/
//   txc  : bit k set for every control lane
// n = 8 yields a plain data word (the /T/ then goes in the next word);
// n = 0 yields the stand-alone terminate word FD 07 07 07 07 07 07 07.
module xgmii_term_word
  import xgmii_pkg::*;
(
  input  logic [63:0] data,
  input  logic [3:0]  n,
  output logic [63:0] txd,
  output logic [7:0]  txc
);

  always_comb begin
    txd = IDLE_WORD;
    txc = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < n) begin
        txd[8*k +: 8] = data[8*k +: 8];
        txc[k]        = 1'b0;
      end else if (4'(k) == n) begin
        txd[8*k +: 8] = XGMII_TERM;
      end
    end
  end

endmodule

// File: rtl/xgmii_tx_encoder.sv
// XGMII transmit encoder: turns the MAC generator's frame words into a
// 64-bit TXD/TXC stream with /S/, /T/, idle fill and a minimum IPG.
//   clk, i_rst_n    : clock, asynchronous active-low reset
//   s_if            : frame-word handshake (slave side)
//   o_txd, o_txc    : registered XGMII data/control, lane 0 in [7:0]
//   o_err           : one-cycle pulse on underrun or runt frame
//   o_frame_count   : frames closed with /T/, wrapping
//   o_err_count     : error events, wrapping
module xgmii_tx_encoder
  import xgmii_pkg::*;
#(
  parameter int P_MIN_IPG   = 12,
  parameter int P_CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  xgmii_tx_encoder_if.slave      s_if,
  output logic [63:0]            o_txd,
  output logic [7:0]             o_txc,
  output logic                   o_err,
  output logic [P_CNT_WIDTH-1:0] o_frame_count,
  output logic [P_CNT_WIDTH-1:0] o_err_count
);

  localparam logic [7:0]             MIN_IPG = 8'(P_MIN_IPG);
  localparam logic [P_CNT_WIDTH-1:0] CNT_ONE = {{(P_CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t      state, state_nxt;
  logic [7:0]  ipg_cnt, ipg_cnt_nxt;
  logic [63:0] txd_nxt;
  logic [7:0]  txc_nxt;
  logic        err_nxt;
  logic        frame_done;
  logic        xfer;
  logic [3:0]  n_last;
  logic [3:0]  term_n;
  logic [63:0] term_txd;
  logic [7:0]  term_txc;

  assign s_if.o_ready = i_rst_n && ((state == IDLE) || (state == DATA));
  assign xfer         = s_if.i_valid && s_if.o_ready;
  assign n_last       = (s_if.i_last_bytes == 3'd0) ? 4'd8 : {1'b0, s_if.i_last_bytes};

  // In TERM no data bytes remain, so the same builder with n = 0 gives FD 07..
  assign term_n = (state == TERM) ? 4'd0 : n_last;

  xgmii_term_word u_term (
    .data (s_if.i_data),
    .n    (term_n),
    .txd  (term_txd),
    .txc  (term_txc)
  );

  always_comb begin
    state_nxt   = state;
    ipg_cnt_nxt = ipg_cnt;
    txd_nxt     = IDLE_WORD;
    txc_nxt     = 8'hFF;
    err_nxt     = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (s_if.i_last) begin
            txd_nxt = ERROR_WORD;
            err_nxt = 1'b1;
          end else begin
            txd_nxt   = {s_if.i_data[63:8], XGMII_START};
            txc_nxt   = 8'h01;
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (!xfer) begin
          // Underrun: flag it in-band and keep the frame open
          txd_nxt = ERROR_WORD;
          err_nxt = 1'b1;
        end else if (!s_if.i_last || (n_last == 4'd8)) begin
          txd_nxt = s_if.i_data;
          txc_nxt = 8'h00;
          if (s_if.i_last) begin
            state_nxt = TERM;
          end
        end else begin
          txd_nxt     = term_txd;
          txc_nxt     = term_txc;
          frame_done  = 1'b1;
          ipg_cnt_nxt = ipg_word_count(MIN_IPG, 8'd7 - {4'd0, n_last});
          state_nxt   = (ipg_cnt_nxt == 8'd0) ? IDLE : IPG;
        end
      end
      TERM: begin
        txd_nxt     = term_txd;
        txc_nxt     = term_txc;
        frame_done  = 1'b1;
        ipg_cnt_nxt = ipg_word_count(MIN_IPG, 8'd7);
        state_nxt   = (ipg_cnt_nxt == 8'd0) ? IDLE : IPG;
      end
      IPG: begin
        ipg_cnt_nxt = ipg_cnt - 8'd1;
        if (ipg_cnt <= 8'd1) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      ipg_cnt       <= 8'd0;
      o_txd         <= IDLE_WORD;
      o_txc         <= 8'hFF;
      o_err         <= 1'b0;
      o_frame_count <= '0;
      o_err_count   <= '0;
    end else begin
      state   <= state_nxt;
      ipg_cnt <= ipg_cnt_nxt;
      o_txd   <= txd_nxt;
      o_txc   <= txc_nxt;
      o_err   <= err_nxt;
      if (frame_done) begin
        o_frame_count <= o_frame_count + CNT_ONE;
      end
      if (err_nxt) begin
        o_err_count <= o_err_count + CNT_ONE;
      end
    end
  end

endmodule
